// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the rv_core RV32I multicycle core.
// Holds opcode and funct3 constants, bus access size encodings, the FSM
// state type and the ALU operation select type.
// The HALT state is present only when RV_CORE_EBREAK_HALT_EN is defined.
package rv_pkg;

  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store funct3
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0;
  localparam logic [2:0] F3_SH   = 3'd1;
  localparam logic [2:0] F3_SW   = 3'd2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_LOAD,
    S_STORE
`ifdef RV_CORE_EBREAK_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational 32-bit integer ALU for rv_core.
// Ports: op (operation select), a/b (operands), y (result),
//        eq/lt/ltu (a==b, signed a<b, unsigned a<b) for branch decisions.
module rv_alu
  import rv_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;
  assign eq  = (a == b);
  assign lt  = (a_s < b_s);
  assign ltu = (a < b);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, lt};
      ALU_SLTU: y = {31'b0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = a_s >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/rv_core.sv
// rv_core: multicycle RV32I core, sole master of one asynchronous 32-bit SRAM.
// Ports: clk, rst (async active-high), data (shared bidirectional bus, driven
//        only while write=1), addr (word address), write/read (strobes),
//        size (00 byte, 01 half, 10 word).
// Sub-word stores are done as read-modify-write since the SRAM has no byte
// enables. Optional macro RV_CORE_EBREAK_HALT_EN makes ECALL/EBREAK halt
// the core until reset; otherwise they execute as NOPs.
module rv_core
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [31:0]       data,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic              read,
  output logic [1:0]        size
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] wdata;
  logic [1:0]  lane;
  logic        rmw;
  logic [31:0] rf [32];

  // Only the store path drives the shared bus.
  assign data = write ? wdata : 'z;

  // ---- Decode ----
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  function automatic alu_op_t f3_to_op(input logic [2:0] fn, input logic alt);
    case (fn)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Pick the addressed byte/halfword out of a fetched word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0] fn,
                                               input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (fn)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'b0, b};
      F3_LHU:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Overlay the low rs2 byte/halfword onto the word read back from SRAM.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] src,
                                              input logic [2:0] fn,
                                              input logic [1:0] ln);
    logic [31:0] m;
    m = w;
    if (fn == F3_SB)  m[{ln, 3'b000} +: 8] = src[7:0];
    else if (ln[1])   m[31:16] = src[15:0];
    else              m[15:0]  = src[15:0];
    return m;
  endfunction

  // ---- Execute ----
  alu_op_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_eq, alu_lt, alu_ltu;

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = rs1_val;
    alu_b  = rs2_val;
    case (opcode)
      OPC_OP: alu_op = f3_to_op(f3, ir[30]);
      OPC_OP_IMM: begin
        alu_b  = imm_i;
        // ir[30] is only an opcode modifier for SRAI; for ADDI it is an imm bit.
        alu_op = f3_to_op(f3, (f3 == F3_SR) && ir[30]);
      end
      OPC_LUI: begin
        alu_a = '0;
        alu_b = imm_u;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
      end
      default: ;
    endcase
  end

  rv_alu u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .eq  (alu_eq),
    .lt  (alu_lt),
    .ltu (alu_ltu)
  );

  logic        taken;
  logic [31:0] pc_plus4, npc, ea;
  logic        unused_ea_hi;

  assign pc_plus4     = pc + 32'd4;
  assign ea           = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign unused_ea_hi = ^ea[31:ADDR_W+2];

  always_comb begin
    case (f3)
      F3_BEQ:  taken = alu_eq;
      F3_BNE:  taken = !alu_eq;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    npc = pc_plus4;
    case (opcode)
      OPC_JAL:    npc = pc + imm_j;
      OPC_JALR:   npc = rs1_val + imm_i;
      OPC_BRANCH: if (taken) npc = pc + imm_b;
      default: ;
    endcase
    // Word-aligned fetch only; this also clears the JALR bit 0.
    npc[1:0] = 2'b00;
  end

  // ---- Register file write-back ----
  logic        rf_we;
  logic [31:0] rf_wd;

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_y;
    case (state)
      S_EXEC: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: rf_we = 1'b1;
          OPC_JAL, OPC_JALR: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
          end
          default: ;
        endcase
      end
      S_LOAD: begin
        rf_we = !rmw;
        rf_wd = load_extract(data, f3, lane);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf[rd] <= rf_wd;
  end

  // Datapath registers carry no reset; they are qualified by the FSM state.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && read) ir <= data;
    if (state == S_EXEC) begin
      lane  <= ea[1:0];
      wdata <= rs2_val;
    end
    if (state == S_LOAD) wdata <= store_merge(data, rs2_val, f3, lane);
  end

  // ---- Control FSM: outputs are set for the state being entered ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      read  <= 1'b0;
      write <= 1'b0;
      addr  <= '0;
      size  <= SZ_W;
      rmw   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // read is low only on the first cycle after reset: issue the fetch.
          if (!read) begin
            read <= 1'b1;
            addr <= pc[ADDR_W+1:2];
            size <= SZ_W;
          end else begin
            read  <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OPC_LOAD: begin
              pc    <= pc_plus4;
              read  <= 1'b1;
              addr  <= ea[ADDR_W+1:2];
              size  <= f3[1:0];
              rmw   <= 1'b0;
              state <= S_LOAD;
            end
            OPC_STORE: begin
              pc   <= pc_plus4;
              addr <= ea[ADDR_W+1:2];
              if (f3[1]) begin
                size  <= SZ_W;
                write <= 1'b1;
                state <= S_STORE;
              end else begin
                size  <= f3[1:0];
                read  <= 1'b1;
                rmw   <= 1'b1;
                state <= S_LOAD;
              end
            end
`ifdef RV_CORE_EBREAK_HALT_EN
            OPC_SYSTEM: begin
              if (f3 == 3'd0 && ir[31:21] == 11'd0) begin
                state <= S_HALT;
              end else begin
                pc    <= pc_plus4;
                read  <= 1'b1;
                addr  <= pc_plus4[ADDR_W+1:2];
                size  <= SZ_W;
                state <= S_FETCH;
              end
            end
`endif
            default: begin
              pc    <= npc;
              read  <= 1'b1;
              addr  <= npc[ADDR_W+1:2];
              size  <= SZ_W;
              state <= S_FETCH;
            end
          endcase
        end
        S_LOAD: begin
          read <= 1'b0;
          if (rmw) begin
            write <= 1'b1;
            state <= S_STORE;
          end else begin
            read  <= 1'b1;
            addr  <= pc[ADDR_W+1:2];
            size  <= SZ_W;
            state <= S_FETCH;
          end
        end
        S_STORE: begin
          write <= 1'b0;
          read  <= 1'b1;
          addr  <= pc[ADDR_W+1:2];
          size  <= SZ_W;
          state <= S_FETCH;
        end
        default: begin
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_core.sv
// tb_rv_core: directed bench for rv_core with a behavioural SRAM on the bus.
module tb_rv_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [31:0] data;
  logic [19:0] addr;
  logic        write;
  logic        read;
  logic [1:0]  size;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        unused_addr_hi;

  rv_core #(.RESET_PC(32'h0000_0000), .ADDR_W(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .addr  (addr),
    .write (write),
    .read  (read),
    .size  (size)
  );

  always #5 clk = ~clk;

  assign data = read ? mem[addr[7:0]] : 'z;
  assign unused_addr_hi = ^addr[19:8];

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    return enc_s(imm, rs2, rs1, 2);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_006F;  // JAL x0,0
  endtask

  task automatic reset_core();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_write(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write && n < 60);
    chk({tag, "_strobe"}, 32'(write), 32'd1);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [31:0] es);
    next_write(tag);
    chk({tag, "_addr"}, 32'(addr), ea);
    chk({tag, "_data"}, data, ed);
    chk({tag, "_size"}, 32'(size), es);
    chk({tag, "_noread"}, 32'(read), 32'd0);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] ea);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!read && n < 60);
    chk({tag, "_read"}, 32'(read), 32'd1);
    chk({tag, "_addr"}, 32'(addr), ea);
  endtask

  initial begin
    int busy;

    // Program A: ADDI x1,x0,5; ADDI x2,x1,-7; SW x2,0x100(x0)
    clear_mem();
    mem[0] = addi(1, 0, 5);
    mem[1] = addi(2, 1, -7);
    mem[2] = sw(2, 0, 32'h100);

    repeat (2) @(negedge clk);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_size", 32'(size), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("f1_read", 32'(read), 32'd1);
    chk("f1_addr", 32'(addr), 32'd0);
    chk("f1_size", 32'(size), 32'd2);
    @(negedge clk);
    chk("exec_read", 32'(read), 32'd0);
    @(negedge clk);
    chk("f2_read", 32'(read), 32'd1);
    chk("f2_addr", 32'(addr), 32'd1);
    expect_write("sw", 32'h40, 32'hFFFF_FFFE, 32'd2);
    chk("sw_cycle", cyc, 7);
    @(negedge clk);
    chk("sw_one_cycle", 32'(write), 32'd0);
    chk("after_sw_fetch", 32'(addr), 32'd3);

    // Reset asserted in the middle of the SW write cycle.
    reset_core();
    next_write("mid");
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_read", 32'(read), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_refetch_read", 32'(read), 32'd1);
    chk("mid_refetch_addr", 32'(addr), 32'd0);

    // Byte store as read-modify-write.
    clear_mem();
    mem[8'h40] = 32'hAABB_CCDD;
    mem[0] = addi(1, 0, 5);
    mem[1] = enc_s(32'h101, 1, 0, 0);
    reset_core();
    repeat (5) @(negedge clk);
    chk("sb_rd_read", 32'(read), 32'd1);
    chk("sb_rd_addr", 32'(addr), 32'h40);
    chk("sb_rd_size", 32'(size), 32'd0);
    @(negedge clk);
    chk("sb_wr_write", 32'(write), 32'd1);
    chk("sb_wr_addr", 32'(addr), 32'h40);
    chk("sb_wr_data", data, 32'hAABB_05DD);
    chk("sb_wr_size", 32'(size), 32'd0);
    @(negedge clk);
    chk("sb_next_fetch", 32'(addr), 32'd2);

    // Loads, each result stored back for observation.
    clear_mem();
    mem[8'h80] = 32'h8011_2233;
    mem[0] = enc_i(32'h203, 0, 0, 3, 7'h03);  // LB  x3
    mem[1] = sw(3, 0, 32'h300);
    mem[2] = enc_i(32'h203, 0, 4, 4, 7'h03);  // LBU x4
    mem[3] = sw(4, 0, 32'h304);
    mem[4] = enc_i(32'h202, 0, 1, 5, 7'h03);  // LH  x5
    mem[5] = sw(5, 0, 32'h308);
    mem[6] = enc_i(32'h200, 0, 2, 6, 7'h03);  // LW  x6
    mem[7] = sw(6, 0, 32'h30C);
    reset_core();
    expect_write("lb", 32'hC0, 32'hFFFF_FF80, 32'd2);
    expect_write("lbu", 32'hC1, 32'h0000_0080, 32'd2);
    expect_write("lh", 32'hC2, 32'hFFFF_8011, 32'd2);
    expect_write("lw", 32'hC3, 32'h8011_2233, 32'd2);

    // Control flow.
    clear_mem();
    mem[0] = addi(1, 0, -1);
    mem[1] = addi(2, 0, 1);
    mem[2] = enc_b(8, 2, 1, 4);               // BLT x1,x2,+8 (taken)
    mem[3] = sw(0, 0, 32'h3F0);
    mem[4] = enc_j(8, 1);                     // JAL x1,+8 at 0x10
    mem[5] = sw(0, 0, 32'h3F4);
    mem[6] = enc_b(16, 2, 1, 0);              // BEQ x1,x2 (not taken)
    mem[7] = addi(0, 0, 7);
    mem[8] = sw(1, 0, 32'h310);
    mem[9] = sw(0, 0, 32'h314);
    reset_core();
    expect_fetch("cf0", 32'd0);
    expect_fetch("cf1", 32'd1);
    expect_fetch("cf2", 32'd2);
    expect_fetch("blt_taken", 32'd4);
    expect_fetch("jal_target", 32'd6);
    expect_fetch("beq_not_taken", 32'd7);
    expect_fetch("cf8", 32'd8);
    expect_write("jal_link", 32'hC4, 32'h0000_0014, 32'd2);
    expect_write("x0_zero", 32'hC5, 32'h0000_0000, 32'd2);

    // ALU operations.
    clear_mem();
    mem[0]  = addi(1, 0, -16);
    mem[1]  = enc_i(32'h402, 1, 5, 2, 7'h13);  // SRAI x2,x1,2
    mem[2]  = enc_i(28, 1, 5, 3, 7'h13);       // SRLI x3,x1,28
    mem[3]  = enc_r(0, 0, 1, 2, 5);            // SLT  x5,x1,x0
    mem[4]  = enc_r(0, 0, 1, 3, 4);            // SLTU x4,x1,x0
    mem[5]  = {20'h12345, 5'd6, 7'h37};        // LUI  x6
    mem[6]  = enc_i(32'hFF, 6, 4, 7, 7'h13);   // XORI x7,x6,0xFF
    mem[7]  = enc_r(32'h20, 1, 3, 0, 8);       // SUB  x8,x3,x1
    mem[8]  = enc_r(0, 3, 3, 1, 9);            // SLL  x9,x3,x3
    mem[9]  = {20'h00001, 5'd10, 7'h17};       // AUIPC x10 at 0x24
    mem[10] = sw(2, 0, 32'h320);
    mem[11] = sw(3, 0, 32'h324);
    mem[12] = sw(5, 0, 32'h328);
    mem[13] = sw(4, 0, 32'h32C);
    mem[14] = sw(7, 0, 32'h330);
    mem[15] = sw(8, 0, 32'h334);
    mem[16] = sw(9, 0, 32'h338);
    mem[17] = sw(10, 0, 32'h33C);
    reset_core();
    expect_write("srai", 32'hC8, 32'hFFFF_FFFC, 32'd2);
    expect_write("srli", 32'hC9, 32'h0000_000F, 32'd2);
    expect_write("slt", 32'hCA, 32'h0000_0001, 32'd2);
    expect_write("sltu", 32'hCB, 32'h0000_0000, 32'd2);
    expect_write("lui_xori", 32'hCC, 32'h1234_50FF, 32'd2);
    expect_write("sub", 32'hCD, 32'h0000_001F, 32'd2);
    expect_write("sll", 32'hCE, 32'h0007_8000, 32'd2);
    expect_write("auipc", 32'hCF, 32'h0000_1024, 32'd2);

    // EBREAK.
    clear_mem();
    mem[0] = 32'h0010_0073;
    reset_core();
    expect_fetch("ebreak_fetch", 32'd0);
`ifdef RV_CORE_EBREAK_HALT_EN
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (read || write) busy++;
    end
    chk("halt_idle_cycles", busy, 0);
`else
    busy = 0;
    expect_fetch("ebreak_nop_next", 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
